// File: rtl/draw_scheduler.sv
// draw_scheduler: frame-level sequencer and pixel-port arbiter for the VGA
// write path. Each frame tick pulses update_en, then starts every enabled
// drawing client in index order, waiting for each one's done before moving
// on. Only the granted client's pixel stream reaches the VGA write port.
// Optional watchdog: define DRAWSCHED_WATCHDOG_EN to abandon a client that
// stays silent for TIMEOUT cycles in S_WAIT. It sets timeout_err.
module draw_scheduler #(
    parameter logic [3:0] CLIENT_EN = 4'b1111,
    parameter logic [9:0] TIMEOUT   = 10'd1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_tick,
    output logic        update_en,
    output logic [3:0]  draw,
    input  logic [3:0]  done,
    input  logic [39:0] c_x,
    input  logic [39:0] c_y,
    input  logic [11:0] c_colour,
    input  logic [3:0]  c_wren,
    output logic [9:0]  vga_x,
    output logic [9:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_wren,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_ISSUE, S_WAIT} state_t;

    state_t     state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    logic       pending_reg, pending_next;
    logic       overrun_reg, overrun_next;

    logic [3:0] above_mask;
    logic [1:0] first_en;
    logic [1:0] next_en;
    logic       has_next;
    logic       wd_fire;
    logic       advance;

    logic [9:0] x_slice [4];
    logic [9:0] y_slice [4];
    logic [2:0] col_slice [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_client
            // Enabled clients strictly above the current grant.
            assign above_mask[gi] = CLIENT_EN[gi] && (2'(gi) > grant_reg);
            assign x_slice[gi]    = c_x[10*gi +: 10];
            assign y_slice[gi]    = c_y[10*gi +: 10];
            assign col_slice[gi]  = c_colour[3*gi +: 3];
        end
    endgenerate

    // Lowest enabled client overall, and lowest enabled client above the grant.
    always_comb begin
        first_en = 2'd0;
        next_en  = 2'd0;
        has_next = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (CLIENT_EN[k]) begin
                first_en = 2'(k);
            end
            if (above_mask[k]) begin
                next_en  = 2'(k);
                has_next = 1'b1;
            end
        end
    end

`ifdef DRAWSCHED_WATCHDOG_EN
    logic [9:0] wd_cnt_reg;
    logic       timeout_reg;

    assign wd_fire     = (state_reg == S_WAIT) && (wd_cnt_reg == TIMEOUT) && !done[grant_reg];
    assign timeout_err = timeout_reg;

    // Watchdog: cleared on each start pulse, saturating count while waiting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt_reg  <= 10'd0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg == S_ISSUE) begin
                wd_cnt_reg <= 10'd0;
            end else if (state_reg == S_WAIT && wd_cnt_reg != 10'h3FF) begin
                wd_cnt_reg <= wd_cnt_reg + 10'd1;
            end
            if (wd_fire) begin
                timeout_reg <= 1'b1;
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign advance = (state_reg == S_WAIT) && (done[grant_reg] || wd_fire);
    assign busy    = (state_reg != S_IDLE);
    assign overrun = overrun_reg;

    // Sequencer next-state, start pulses and frame-tick bookkeeping.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        update_en    = 1'b0;
        draw         = 4'b0000;
        case (state_reg)
            S_IDLE: begin
                if (frame_tick || pending_reg) begin
                    pending_next = 1'b0;
                    state_next   = S_UPDATE;
                end
            end
            S_UPDATE: begin
                update_en = 1'b1;
                if (CLIENT_EN == 4'b0000) begin
                    state_next = S_IDLE;
                end else begin
                    grant_next = first_en;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                draw       = 4'b0001 << grant_reg;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (advance) begin
                    if (has_next) begin
                        grant_next = next_en;
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        // One tick may be queued while busy; a second one is lost.
        if (state_reg != S_IDLE && frame_tick) begin
            if (pending_reg) begin
                overrun_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            grant_reg   <= 2'd0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    // Registered pixel mux; write strobe only passes while a client holds the grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_x      <= 10'd0;
            vga_y      <= 10'd0;
            vga_colour <= 3'd0;
            vga_wren   <= 1'b0;
        end else begin
            vga_x      <= x_slice[grant_reg];
            vga_y      <= y_slice[grant_reg];
            vga_colour <= col_slice[grant_reg];
            vga_wren   <= c_wren[grant_reg] && (state_reg == S_ISSUE || state_reg == S_WAIT);
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler: two instances (all clients enabled, and
// clients 1 and 3 only) driven by randomized client delays, done noise and
// pixel traffic. Expected event times come from the frame schedule rules.
module tb_draw_scheduler;

    localparam logic [9:0] TB_TIMEOUT = 10'd1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        frame_tick;
    logic [39:0] c_x, c_y;
    logic [11:0] c_colour;
    logic [3:0]  c_wren;

    logic [3:0]  done_v   [2];
    logic        upd_v    [2];
    logic [3:0]  draw_v   [2];
    logic [9:0]  vx_v     [2];
    logic [9:0]  vy_v     [2];
    logic [2:0]  vc_v     [2];
    logic        vw_v     [2];
    logic        busy_v   [2];
    logic        ovr_v    [2];
    logic        terr_v   [2];

    draw_scheduler #(.CLIENT_EN(4'b1111), .TIMEOUT(TB_TIMEOUT)) dut_a (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .update_en(upd_v[0]), .draw(draw_v[0]), .done(done_v[0]),
        .c_x(c_x), .c_y(c_y), .c_colour(c_colour), .c_wren(c_wren),
        .vga_x(vx_v[0]), .vga_y(vy_v[0]), .vga_colour(vc_v[0]), .vga_wren(vw_v[0]),
        .busy(busy_v[0]), .overrun(ovr_v[0]), .timeout_err(terr_v[0])
    );

    draw_scheduler #(.CLIENT_EN(4'b1010), .TIMEOUT(TB_TIMEOUT)) dut_b (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .update_en(upd_v[1]), .draw(draw_v[1]), .done(done_v[1]),
        .c_x(c_x), .c_y(c_y), .c_colour(c_colour), .c_wren(c_wren),
        .vga_x(vx_v[1]), .vga_y(vy_v[1]), .vga_colour(vc_v[1]), .vga_wren(vw_v[1]),
        .busy(busy_v[1]), .overrun(ovr_v[1]), .timeout_err(terr_v[1])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rst_at   = 0;
    bit rst_seen = 1'b1;

    logic [3:0] mask [2];
    int  exp_upd    [2][$];
    int  exp_draw_t [2][$];
    int  exp_draw_v [2][$];
    int  exp_idle   [2][$];
    bit  exp_ovr    [2];
    bit  exp_terr   [2];
    int  due        [2][4];
    int  act        [2];
    int  prev_act   [2];
    bit  prev_busy  [2];
    int  dly        [4];
    bit [3:0] stall;
    int  tick_at [$];
    logic [39:0] p_x, p_y;
    logic [11:0] p_col;
    logic [3:0]  p_wren;

    task automatic check(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (exp_upd[i].size() != 0 || exp_draw_t[i].size() != 0 || exp_idle[i].size() != 0)
                e = 1'b0;
        end
        return e;
    endfunction

    // Expected schedule of one frame whose tick is seen in S_IDLE at cycle tk.
    // Returns the cycle at which the scheduler is idle again, or -1 if it hangs.
    function automatic int push_frame(input int i, input int tk);
        int t;
        int d;
        exp_upd[i].push_back(tk + 1);
        t = tk + 2;
        for (int k = 0; k < 4; k++) begin
            if (mask[i][k]) begin
                exp_draw_t[i].push_back(t);
                exp_draw_v[i].push_back(1 << k);
                if (stall[k]) begin
`ifdef DRAWSCHED_WATCHDOG_EN
                    d = int'(TB_TIMEOUT) + 1;
                    exp_terr[i] = 1'b1;
`else
                    return -1;
`endif
                end else begin
                    d = dly[k];
                end
                t = t + d + 1;
            end
        end
        exp_idle[i].push_back(t);
        return t;
    endfunction

    task automatic step();
        int e;
        int kk;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst_seen) begin
                check("rst_update_en", int'(upd_v[i]), 0);
                check("rst_draw", int'(draw_v[i]), 0);
                check("rst_busy", int'(busy_v[i]), 0);
                check("rst_vga_x", int'(vx_v[i]), 0);
                check("rst_vga_y", int'(vy_v[i]), 0);
                check("rst_vga_colour", int'(vc_v[i]), 0);
                check("rst_vga_wren", int'(vw_v[i]), 0);
                check("rst_overrun", int'(ovr_v[i]), 0);
                check("rst_timeout_err", int'(terr_v[i]), 0);
                exp_upd[i].delete();
                exp_draw_t[i].delete();
                exp_draw_v[i].delete();
                exp_idle[i].delete();
                exp_ovr[i]  = 1'b0;
                exp_terr[i] = 1'b0;
                act[i]      = -1;
                prev_act[i] = -1;
                for (int k = 0; k < 4; k++) due[i][k] = -1;
            end else begin
                if (upd_v[i]) begin
                    e = (exp_upd[i].size() > 0) ? exp_upd[i].pop_front() : -1;
                    check("update_en_time", cyc, e);
                end
                if (draw_v[i] != 4'b0000) begin
                    e = (exp_draw_t[i].size() > 0) ? exp_draw_t[i].pop_front() : -1;
                    check("draw_time", cyc, e);
                    e = (exp_draw_v[i].size() > 0) ? exp_draw_v[i].pop_front() : 0;
                    check("draw_value", int'(draw_v[i]), e);
                end
                if (prev_busy[i] && !busy_v[i]) begin
                    e = (exp_idle[i].size() > 0) ? exp_idle[i].pop_front() : -1;
                    check("busy_fall_time", cyc, e);
                end
                if (prev_act[i] >= 0) begin
                    kk = prev_act[i];
                    check("vga_wren", int'(vw_v[i]), int'(p_wren[kk]));
                    check("vga_x", int'(vx_v[i]), int'(p_x[10*kk +: 10]));
                    check("vga_y", int'(vy_v[i]), int'(p_y[10*kk +: 10]));
                    check("vga_colour", int'(vc_v[i]), int'(p_col[3*kk +: 3]));
                end else begin
                    check("vga_wren_ungranted", int'(vw_v[i]), 0);
                end
            end
            prev_busy[i] = busy_v[i];
        end

        rst_seen = 1'b0;
        resetn = (cyc == rst_at) ? 1'b0 : 1'b1;
        if (!resetn) rst_seen = 1'b1;
        frame_tick = 1'b0;
        foreach (tick_at[j]) if (tick_at[j] == cyc) frame_tick = 1'b1;
        c_x      = {8'($urandom), $urandom};
        c_y      = {8'($urandom), $urandom};
        c_colour = 12'($urandom);
        c_wren   = 4'($urandom);
        p_x = c_x; p_y = c_y; p_col = c_colour; p_wren = c_wren;

        // Client emulation: done dly[k] cycles after draw, plus ignorable noise.
        for (int i = 0; i < 2; i++) begin
            kk = -1;
            for (int k = 0; k < 4; k++) if (draw_v[i][k]) kk = k;
            if (kk >= 0) begin
                act[i] = kk;
                due[i][kk] = stall[kk] ? -1 : cyc + dly[kk];
            end
            for (int k = 0; k < 4; k++) begin
                if (k == act[i])
                    done_v[i][k] = (due[i][k] == cyc) || (kk == k && $urandom_range(0, 1) == 1);
                else
                    done_v[i][k] = ($urandom_range(0, 3) == 0);
            end
            prev_act[i] = act[i];
            if (act[i] >= 0 && due[i][act[i]] == cyc) act[i] = -1;
        end
    endtask

    task automatic run_frame(input int n_extra, input bit [3:0] stall_mask,
                             input int budget, input bit expect_hang, input bit mid_reset);
        int tk;
        int b;
        for (int k = 0; k < 4; k++) dly[k] = $urandom_range(1, 8);
        stall = stall_mask;
        tk = cyc + 1;
        tick_at.delete();
        for (int j = 0; j <= n_extra; j++) tick_at.push_back(tk + 2*j);
        if (mid_reset) rst_at = tk + 2 + dly[0] + 1 + 1;
        for (int i = 0; i < 2; i++) begin
            b = push_frame(i, tk);
            if (n_extra >= 1 && b > 0) void'(push_frame(i, b));
            if (n_extra >= 2) exp_ovr[i] = 1'b1;
        end
        for (int n = 0; n < budget; n++) begin
            step();
            if (!expect_hang && all_empty() && !rst_seen) break;
        end
        if (!expect_hang) check("frame_complete", int'(all_empty()), 1);
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            check("overrun", int'(ovr_v[i]), int'(exp_ovr[i]));
            check("timeout_err", int'(terr_v[i]), int'(exp_terr[i]));
        end
        $display("frame tick@%0d extra_ticks=%0d stall=%b dly=%0d/%0d/%0d/%0d end@%0d",
                 tk, n_extra, stall_mask, dly[0], dly[1], dly[2], dly[3], cyc);
    endtask

    initial begin
        resetn = 1'b0;
        frame_tick = 1'b0;
        c_x = '0; c_y = '0; c_colour = '0; c_wren = '0;
        mask[0] = 4'b1111;
        mask[1] = 4'b1010;
        stall = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            done_v[i] = 4'b0000;
            act[i] = -1;
            prev_act[i] = -1;
            prev_busy[i] = 1'b0;
            exp_ovr[i] = 1'b0;
            exp_terr[i] = 1'b0;
            for (int k = 0; k < 4; k++) due[i][k] = -1;
        end
        for (int k = 0; k < 4; k++) dly[k] = 1;

        repeat (6) step();

        // Plain frames with random client latencies.
        for (int f = 0; f < 6; f++) run_frame(0, 4'b0000, 200, 1'b0, 1'b0);

        // One queued tick, then a frame that loses a tick.
        run_frame(1, 4'b0000, 300, 1'b0, 1'b0);
        run_frame(2, 4'b0000, 300, 1'b0, 1'b0);

        // Reset clears the sticky overrun flag.
        rst_at = cyc + 1;
        step();
        step();
        repeat (3) step();

        // Reset while client 1 is being waited on: nothing may follow.
        run_frame(0, 4'b0000, 60, 1'b0, 1'b1);
        repeat (20) step();
        check("after_reset_quiet", int'(all_empty()), 1);

`ifdef DRAWSCHED_WATCHDOG_EN
        // Client 2 never finishes; the watchdog moves on to client 3.
        run_frame(0, 4'b0100, 3000, 1'b0, 1'b0);
`else
        // Client 2 never finishes; the scheduler must keep waiting.
        run_frame(0, 4'b0100, 3000, 1'b1, 1'b0);
        check("hang_busy", int'(busy_v[0]), 1);
        check("hang_draw_queue", exp_draw_t[0].size(), 0);
        rst_at = cyc + 1;
        step();
        step();
        repeat (3) step();
`endif

        run_frame(0, 4'b0000, 200, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
